// File: rtl/medyan_dagitici_pkg.sv
// Shared constants and slot state encoding for the median scheduler.
// Watchdog feature macro: MEDYAN_ZAMAN_ASIMI_EN
package medyan_dagitici_pkg;

    localparam int unsigned PENCERE_PIXEL = 9;
    localparam int unsigned SAYAC_BIT     = 4;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        YUKLE = 2'd1,
        BEKLE = 2'd2,
        SONUC = 2'd3
    } yuva_durum_t;

endpackage

// File: rtl/medyan_yuva.sv
// One scheduler slot: latches a window, feeds its pixels serially to its
// median unit, waits for the result and holds it until it is drained.
// MEDYAN_ZAMAN_ASIMI_EN adds a per-slot watchdog while waiting for the unit.
module medyan_yuva
    import medyan_dagitici_pkg::*;
#(
    parameter int unsigned PIXEL_BIT = 8
`ifdef MEDYAN_ZAMAN_ASIMI_EN
    , parameter int unsigned ZAMAN_ASIMI = 64
`endif
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 yukle_i,
    input  logic [PENCERE_PIXEL*PIXEL_BIT-1:0]   pencere_i,
    input  logic                                 hazir_i,
    input  logic [PIXEL_BIT-1:0]                 medyan_i,
    input  logic                                 bosalt_i,
    output yuva_durum_t                          durum_o,
    output logic                                 etkin_o,
    output logic [PIXEL_BIT-1:0]                 sayi_o,
    output logic [PIXEL_BIT-1:0]                 sonuc_o,
    output logic                                 hata_c
);

    localparam int unsigned PENCERE_BIT = PENCERE_PIXEL * PIXEL_BIT;

    yuva_durum_t              durum_q, durum_d;
    logic [PENCERE_BIT-1:0]   kaydirma_q, kaydirma_d;
    logic [SAYAC_BIT-1:0]     sayac_q, sayac_d;
    logic                     etkin_q, etkin_d;
    logic [PIXEL_BIT-1:0]     sayi_q, sayi_d;
    logic [PIXEL_BIT-1:0]     sonuc_q, sonuc_d;

`ifdef MEDYAN_ZAMAN_ASIMI_EN
    localparam int unsigned BEKCI_BIT = $clog2(ZAMAN_ASIMI + 1);
    logic [BEKCI_BIT-1:0]     bekci_q, bekci_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q    <= BOS;
            kaydirma_q <= '0;
            sayac_q    <= '0;
            etkin_q    <= 1'b0;
            sayi_q     <= '0;
            sonuc_q    <= '0;
`ifdef MEDYAN_ZAMAN_ASIMI_EN
            bekci_q    <= '0;
`endif
        end else begin
            durum_q    <= durum_d;
            kaydirma_q <= kaydirma_d;
            sayac_q    <= sayac_d;
            etkin_q    <= etkin_d;
            sayi_q     <= sayi_d;
            sonuc_q    <= sonuc_d;
`ifdef MEDYAN_ZAMAN_ASIMI_EN
            bekci_q    <= bekci_d;
`endif
        end
    end

    // Next state: byte 0 goes out the cycle after accept, then one byte per
    // cycle until the ninth; the strobe and pixel are zero outside the feed.
    always_comb begin
        durum_d    = durum_q;
        kaydirma_d = kaydirma_q;
        sayac_d    = sayac_q;
        etkin_d    = 1'b0;
        sayi_d     = '0;
        sonuc_d    = sonuc_q;
        hata_c     = 1'b0;
`ifdef MEDYAN_ZAMAN_ASIMI_EN
        bekci_d    = '0;
`endif
        unique case (durum_q)
            BOS: begin
                if (yukle_i) begin
                    durum_d    = YUKLE;
                    etkin_d    = 1'b1;
                    sayi_d     = pencere_i[PIXEL_BIT-1:0];
                    kaydirma_d = pencere_i >> PIXEL_BIT;
                    sayac_d    = SAYAC_BIT'(1);
                end
            end
            YUKLE: begin
                if (sayac_q == SAYAC_BIT'(PENCERE_PIXEL)) begin
                    durum_d = BEKLE;
                end else begin
                    etkin_d    = 1'b1;
                    sayi_d     = kaydirma_q[PIXEL_BIT-1:0];
                    kaydirma_d = kaydirma_q >> PIXEL_BIT;
                    sayac_d    = sayac_q + SAYAC_BIT'(1);
                end
            end
            BEKLE: begin
                if (hazir_i) begin
                    sonuc_d = medyan_i;
                    durum_d = SONUC;
                end
`ifdef MEDYAN_ZAMAN_ASIMI_EN
                else if (bekci_q == BEKCI_BIT'(ZAMAN_ASIMI - 1)) begin
                    sonuc_d = '0;
                    durum_d = SONUC;
                    hata_c  = 1'b1;
                end else begin
                    bekci_d = bekci_q + BEKCI_BIT'(1);
                end
`endif
            end
            SONUC: begin
                if (bosalt_i) begin
                    durum_d = BOS;
                end
            end
        endcase
        // A result strobe outside BEKLE is dropped and reported.
        if (hazir_i && (durum_q != BEKLE)) begin
            hata_c = 1'b1;
        end
    end

    assign durum_o = durum_q;
    assign etkin_o = etkin_q;
    assign sayi_o  = sayi_q;
    assign sonuc_o = sonuc_q;

endmodule

// File: rtl/medyan_dagitici.sv
// Median scheduler: distributes 3x3 windows round-robin over BIRIM_SAYISI
// median units and returns their results in window-arrival order.
// Optional watchdog: define MEDYAN_ZAMAN_ASIMI_EN.
module medyan_dagitici
    import medyan_dagitici_pkg::*;
#(
    parameter int unsigned BIRIM_SAYISI = 10,
    parameter int unsigned PIXEL_BIT    = 8,
    parameter int unsigned ZAMAN_ASIMI  = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   pencere_gecerli_i,
    input  logic [PENCERE_PIXEL*PIXEL_BIT-1:0]     pencere_i,
    output logic                                   pencere_hazir_o,
    output logic [BIRIM_SAYISI-1:0]                birim_etkin_o,
    output logic [BIRIM_SAYISI*PIXEL_BIT-1:0]      birim_sayi_o,
    input  logic [BIRIM_SAYISI*PIXEL_BIT-1:0]      birim_medyan_i,
    input  logic [BIRIM_SAYISI-1:0]                birim_hazir_i,
    output logic                                   cikis_gecerli_o,
    input  logic                                   cikis_hazir_i,
    output logic [PIXEL_BIT-1:0]                   pixel_o,
    output logic [$clog2(BIRIM_SAYISI+1)-1:0]      doluluk_o,
    output logic                                   hata_o
);

    localparam int unsigned PTR_BIT     = $clog2(BIRIM_SAYISI);
    localparam int unsigned DOLULUK_BIT = $clog2(BIRIM_SAYISI + 1);

    logic [PTR_BIT-1:0]      giris_ptr_q, cikis_ptr_q;
    logic [DOLULUK_BIT-1:0]  doluluk_q;
    logic                    hata_q;

    yuva_durum_t             durum [BIRIM_SAYISI];
    logic [PIXEL_BIT-1:0]    sonuc [BIRIM_SAYISI];
    logic [BIRIM_SAYISI-1:0] yukle, bosalt, yuva_hata;
    logic                    kabul, teslim;

    // Without the watchdog the limit has no effect; a zero limit is never valid.
    if (ZAMAN_ASIMI == 0) begin : g_gecersiz_zaman_asimi
    end

    // Handshakes are decided purely from registered slot state.
    assign pencere_hazir_o = (durum[giris_ptr_q] == BOS);
    assign cikis_gecerli_o = (durum[cikis_ptr_q] == SONUC);
    assign pixel_o         = sonuc[cikis_ptr_q];
    assign kabul           = pencere_gecerli_i && pencere_hazir_o;
    assign teslim          = cikis_gecerli_o && cikis_hazir_i;
    assign doluluk_o       = doluluk_q;
    assign hata_o          = hata_q;

    // Slot array; only the slot under the matching pointer sees accept/drain.
    for (genvar j = 0; j < BIRIM_SAYISI; j++) begin : g_yuva
        assign yukle[j]  = kabul  && (giris_ptr_q == PTR_BIT'(j));
        assign bosalt[j] = teslim && (cikis_ptr_q == PTR_BIT'(j));

        medyan_yuva #(
            .PIXEL_BIT   (PIXEL_BIT)
`ifdef MEDYAN_ZAMAN_ASIMI_EN
            , .ZAMAN_ASIMI (ZAMAN_ASIMI)
`endif
        ) u_yuva (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .yukle_i   (yukle[j]),
            .pencere_i (pencere_i),
            .hazir_i   (birim_hazir_i[j]),
            .medyan_i  (birim_medyan_i[j*PIXEL_BIT +: PIXEL_BIT]),
            .bosalt_i  (bosalt[j]),
            .durum_o   (durum[j]),
            .etkin_o   (birim_etkin_o[j]),
            .sayi_o    (birim_sayi_o[j*PIXEL_BIT +: PIXEL_BIT]),
            .sonuc_o   (sonuc[j]),
            .hata_c    (yuva_hata[j])
        );
    end

    // Round-robin input and output pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            giris_ptr_q <= '0;
            cikis_ptr_q <= '0;
        end else begin
            if (kabul) begin
                giris_ptr_q <= (giris_ptr_q == PTR_BIT'(BIRIM_SAYISI - 1)) ?
                               '0 : giris_ptr_q + PTR_BIT'(1);
            end
            if (teslim) begin
                cikis_ptr_q <= (cikis_ptr_q == PTR_BIT'(BIRIM_SAYISI - 1)) ?
                               '0 : cikis_ptr_q + PTR_BIT'(1);
            end
        end
    end

    // Occupancy: accept and drain in the same cycle cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            doluluk_q <= '0;
        end else begin
            unique case ({kabul, teslim})
                2'b10:   doluluk_q <= doluluk_q + DOLULUK_BIT'(1);
                2'b01:   doluluk_q <= doluluk_q - DOLULUK_BIT'(1);
                default: doluluk_q <= doluluk_q;
            endcase
        end
    end

    // Sticky error collecting spurious result strobes and watchdog expiries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hata_q <= 1'b0;
        end else begin
            hata_q <= hata_q | (|yuva_hata);
        end
    end

endmodule
